ldst_bus_master: RTL and testbench

Load/store initiator that sits between the CPU execute stage and the word-organised RAM's shared bidirectional data bus. Accepts one byte/half/word load or store request at a time, drives the RAM's address, write-enable and tri-state data lines, captures read data, and returns a single-cycle response. Sub-word stores use an internal read-modify-write sequence, so the RAM only ever sees whole-word writes.

---
 rtl/ldst_bus_master.sv | 203 ++++++++++++++++++++
 tb/tb_ldst_bus_master.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ldst_bus_master.sv
// Load/store initiator for a word-organised RAM on a shared tri-state data bus.
// Optional feature: define LDST_MISALIGN_TRAP_EN to reject misaligned half/word accesses.
module ldst_bus_master #(
    parameter int unsigned addr_width = 32,
    parameter int unsigned data_width = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [addr_width-1:0] req_addr,
    input  logic [data_width-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [data_width-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [addr_width-1:0] mem_addr,
    output logic                  mem_wen,
    inout  wire  [data_width-1:0] mem_data
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    // Selected lane shifted down to bit 0 and zero/sign extended.
    function automatic logic [31:0] lane_extract(input logic [31:0] w, input logic [1:0] off,
                                                 input logic [1:0] sz, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (sz)
            SZ_BYTE: r = {{24{sgn & b[7]}}, b};
            SZ_HALF: r = {{16{sgn & h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    // Old word with the addressed lane(s) replaced by right-aligned store data.
    function automatic logic [31:0] lane_merge(input logic [31:0] w, input logic [31:0] d,
                                               input logic [1:0] off, input logic [1:0] sz);
        logic [31:0] r;
        r = w;
        case (sz)
            SZ_BYTE: begin
                case (off)
                    2'd0:    r[7:0]   = d[7:0];
                    2'd1:    r[15:8]  = d[7:0];
                    2'd2:    r[23:16] = d[7:0];
                    default: r[31:24] = d[7:0];
                endcase
            end
            SZ_HALF: begin
                if (off[1]) r[31:16] = d[15:0];
                else        r[15:0]  = d[15:0];
            end
            default: r = d;
        endcase
        return r;
    endfunction

    logic [1:0]            state_q, state_d;
    logic                  ready_q, ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [data_width-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [addr_width-1:0] mem_addr_q, mem_addr_d;
    logic                  mem_wen_q, mem_wen_d;
    logic [data_width-1:0] bus_q, bus_d;
    logic                  we_q, we_d;
    logic [1:0]            size_q, size_d;
    logic                  sgn_q, sgn_d;
    logic [1:0]            off_q, off_d;
    logic [data_width-1:0] wdata_q, wdata_d;
    logic                  trap;

    always_comb begin
`ifdef LDST_MISALIGN_TRAP_EN
        trap = ((req_size == SZ_HALF) && req_addr[0]) ||
               (req_size[1] && (req_addr[1:0] != 2'b00));
`else
        trap = 1'b0;
`endif
    end

    // Next-state and next-output logic; all outputs are registered from these.
    always_comb begin
        state_d     = state_q;
        ready_d     = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wen_d   = 1'b0;
        bus_d       = bus_q;
        we_d        = we_q;
        size_d      = size_q;
        sgn_d       = sgn_q;
        off_d       = off_q;
        wdata_d     = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid && ready_q) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    sgn_d   = req_signed;
                    off_d   = req_addr[1:0];
                    wdata_d = req_wdata;
                    if (trap) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        mem_addr_d = {2'b00, req_addr[addr_width-1:2]};
                        if (req_we && req_size[1]) begin
                            state_d   = S_WRITE;
                            mem_wen_d = 1'b1;
                            bus_d     = req_wdata;
                        end else begin
                            state_d = S_READ;
                        end
                    end
                end else begin
                    ready_d = 1'b1;
                end
            end
            S_READ: begin
                if (we_q) begin
                    state_d   = S_WRITE;
                    mem_wen_d = 1'b1;
                    bus_d     = lane_merge(mem_data, wdata_q, off_q, size_q);
                end else begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = lane_extract(mem_data, off_q, size_q, sgn_q);
                end
            end
            S_WRITE: begin
                state_d     = S_RESP;
                rsp_valid_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wen_q   <= 1'b0;
            bus_q       <= '0;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            sgn_q       <= 1'b0;
            off_q       <= 2'b00;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            mem_addr_q  <= mem_addr_d;
            mem_wen_q   <= mem_wen_d;
            bus_q       <= bus_d;
            we_q        <= we_d;
            size_q      <= size_d;
            sgn_q       <= sgn_d;
            off_q       <= off_d;
            wdata_q     <= wdata_d;
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wen   = mem_wen_q;
    assign mem_data  = mem_wen_q ? bus_q : {data_width{1'bz}};

endmodule

// File: tb/tb_ldst_bus_master.sv
// Directed bench for ldst_bus_master: RAM model on the shared bus plus a response scoreboard.
module tb_ldst_bus_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic        mem_wen;
    wire  [31:0] mem_data;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;
    rsp_t exp_q[$];

    logic [31:0] ram [0:255];

    always #5 clk = ~clk;

    ldst_bus_master dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_addr   (mem_addr),
        .mem_wen    (mem_wen),
        .mem_data   (mem_data)
    );

    // RAM drives the bus only when the master is not writing and not in reset
    assign mem_data = (rst_n && !mem_wen) ? ram[mem_addr[7:0]] : 32'bz;
    always @(posedge clk) if (mem_wen) ram[mem_addr[7:0]] <= mem_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every response pulse must match the oldest pending expectation
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            rsp_t e;
            chk("rsp_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
            end
        end
    end

    task automatic req(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee,
                       input int elat, input int erd, input int ewen, input string tag);
        int lat, rd, wn, guard;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        exp_q.push_back({er, ee});
        @(posedge clk);
        #1;
        // Keep garbage requests asserted while busy; they must be ignored
        req_we     = 1'($urandom);
        req_size   = 2'($urandom);
        req_signed = 1'($urandom);
        req_addr   = $urandom & 32'h0000_00FC;
        req_wdata  = $urandom;
        lat = 0;
        rd  = 0;
        wn  = 0;
        do begin
            @(negedge clk);
            lat++;
            if (mem_wen) wn++;
            if (!mem_wen && !req_ready && !rsp_valid) rd++;
            if (lat == 1 && elat > 1) chk({tag, "_mem_addr"}, mem_addr, {2'b00, a[31:2]});
        end while (!rsp_valid && lat < 10);
        req_valid = 1'b0;
        chk({tag, "_latency"}, 32'(lat), 32'(elat));
        chk({tag, "_read_cycles"}, 32'(rd), 32'(erd));
        chk({tag, "_wen_cycles"}, 32'(wn), 32'(ewen));
        @(negedge clk);
        chk({tag, "_pulse_end"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_ready_back"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_wen", 32'(mem_wen), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_ready_before_edge", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("rel_ready_after_edge", 32'(req_ready), 32'd1);
        chk("rel_wen", 32'(mem_wen), 32'd0);

        // Word store then load
        req(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2, 0, 1, "st_w_10");
        req(0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 2, 1, 0, "ld_w_10");

        // Byte store read-modify-write
        req(1, 2'b10, 0, 32'h20, 32'h11223344, 32'h0, 0, 2, 0, 1, "st_w_20");
        req(1, 2'b00, 0, 32'h21, 32'hFFFFFFAA, 32'h0, 0, 3, 1, 1, "st_b_21");
        req(0, 2'b10, 0, 32'h20, 32'h0, 32'h1122AA44, 0, 2, 1, 0, "ld_w_20");

        // Load extraction and extension
        req(1, 2'b10, 0, 32'h30, 32'h80FF7F01, 32'h0, 0, 2, 0, 1, "st_w_30");
        req(0, 2'b00, 1, 32'h32, 32'h0, 32'hFFFFFFFF, 0, 2, 1, 0, "ld_bs_32");
        req(0, 2'b01, 0, 32'h32, 32'h0, 32'h000080FF, 0, 2, 1, 0, "ld_hu_32");
        req(0, 2'b01, 1, 32'h30, 32'h0, 32'h00007F01, 0, 2, 1, 0, "ld_hs_30");
        req(0, 2'b01, 1, 32'h32, 32'h0, 32'hFFFF80FF, 0, 2, 1, 0, "ld_hs_32");
        req(0, 2'b00, 1, 32'h33, 32'h0, 32'hFFFFFF80, 0, 2, 1, 0, "ld_bs_33");
        req(0, 2'b00, 0, 32'h33, 32'h0, 32'h00000080, 0, 2, 1, 0, "ld_bu_33");
        req(0, 2'b00, 0, 32'h31, 32'h0, 32'h0000007F, 0, 2, 1, 0, "ld_bu_31");

        // Half store and misalignment handling
        req(1, 2'b10, 0, 32'h40, 32'h55667788, 32'h0, 0, 2, 0, 1, "st_w_40");
        req(1, 2'b01, 0, 32'h42, 32'hABCD1234, 32'h0, 0, 3, 1, 1, "st_h_42");
        req(0, 2'b10, 0, 32'h40, 32'h0, 32'h12347788, 0, 2, 1, 0, "ld_w_40");
`ifdef LDST_MISALIGN_TRAP_EN
        req(0, 2'b10, 0, 32'h41, 32'h0, 32'h0, 1, 1, 0, 0, "ld_w_41_mis");
        req(0, 2'b01, 0, 32'h43, 32'h0, 32'h0, 1, 1, 0, 0, "ld_h_43_mis");
        req(1, 2'b10, 0, 32'h42, 32'h99999999, 32'h0, 1, 1, 0, 0, "st_w_42_mis");
        req(0, 2'b10, 0, 32'h40, 32'h0, 32'h12347788, 0, 2, 1, 0, "ld_w_40_again");
`else
        req(0, 2'b10, 0, 32'h41, 32'h0, 32'h12347788, 0, 2, 1, 0, "ld_w_41");
        req(0, 2'b01, 0, 32'h43, 32'h0, 32'h00001234, 0, 2, 1, 0, "ld_h_43");
`endif

        // Size 11 behaves as a word
        req(1, 2'b11, 0, 32'h60, 32'hA5A55A5A, 32'h0, 0, 2, 0, 1, "st_w3_60");
        req(0, 2'b11, 1, 32'h60, 32'h0, 32'hA5A55A5A, 0, 2, 1, 0, "ld_w3_60");

        // Reset during the read phase of a byte store
        req(1, 2'b10, 0, 32'h50, 32'hCAFEF00D, 32'h0, 0, 2, 0, 1, "st_w_50");
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'h51;
        req_wdata  = 32'h00000077;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("abort_in_read_wen", 32'(mem_wen), 32'd0);
        chk("abort_in_read_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_wen", 32'(mem_wen), 32'd0);
        chk("abort_ready", 32'(req_ready), 32'd0);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_hold_rsp", 32'(rsp_valid), 32'd0);
            chk("abort_hold_wen", 32'(mem_wen), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_ready_back", 32'(req_ready), 32'd1);
        chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
        chk("abort_sb_empty", 32'(exp_q.size()), 32'd0);
        req(0, 2'b10, 0, 32'h50, 32'h0, 32'hCAFEF00D, 0, 2, 1, 0, "ld_w_50");

        repeat (2) @(negedge clk);
        chk("final_sb_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
